// File: rtl/multiply_32_unit.sv
// -----------------------------------------------------------------------------
// multiply_32_unit
// Sequential unsigned N x N shift-and-add multiplier, one multiplier bit per
// clock. The 2N-bit product lives in the {A,Q} register pair and is presented
// directly from those registers, so there is no combinational path from any
// input to any output.
//
// Ports
//   clk           : single clock, all state updates on the rising edge
//   reset         : synchronous, active-low reset
//   enable        : start request, only sampled while ready = 1
//   multiplier    : unsigned operand Q, captured on the start edge
//   multiplicand  : unsigned operand M, captured on the start edge
//   ready         : 1 = idle with a valid product, 0 = busy
//   product_upper : high N bits of the product (A register)
//   product_lower : low N bits of the product (Q register)
//   cout          : carry register C
// -----------------------------------------------------------------------------
module multiply_32_unit #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic [N-1:0] multiplier,
   input  logic [N-1:0] multiplicand,
   output logic         ready,
   output logic [N-1:0] product_upper,
   output logic [N-1:0] product_lower,
   output logic         cout
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t          state_q;
   logic [N-1:0]    a_q;
   logic [N-1:0]    q_q;
   logic [N-1:0]    m_q;
   logic            c_q;
   logic [CW-1:0]   cnt_q;

   // One iteration of the algorithm: conditional add into {C,A}, followed by
   // a logical right shift of {C,A,Q}. C is always shifted out as 0, so only
   // the shifted A and Q need a next-state value.
   logic [N:0]      sum_d;
   logic [N-1:0]    a_d;
   logic [N-1:0]    q_d;

   always_comb begin
      sum_d = {1'b0, a_q};
      if (q_q[0]) begin
         sum_d = {1'b0, a_q} + {1'b0, m_q};
      end
      a_d = sum_d[N:1];
      q_d = {sum_d[0], q_q[N-1:1]};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         q_q     <= '0;
         m_q     <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               // Without a start request every register holds, so the last
               // product stays visible.
               if (enable) begin
                  a_q     <= '0;
                  c_q     <= 1'b0;
                  q_q     <= multiplier;
                  m_q     <= multiplicand;
                  cnt_q   <= '0;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               a_q   <= a_d;
               q_q   <= q_d;
               c_q   <= 1'b0;
               cnt_q <= cnt_q + CW'(1);
               // The step finishing now is the N-th one.
               if (cnt_q == CW'(N - 1)) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ready         = (state_q == IDLE);
   assign product_upper = a_q;
   assign product_lower = q_q;
   assign cout          = c_q;

endmodule

// File: tb/tb_multiply_32_unit.sv
// -----------------------------------------------------------------------------
// tb_multiply_32_unit
// Self-checking bench for multiply_32_unit. Expected products come from plain
// 64-bit multiplication of the operands; expected latency and ready behaviour
// come from the documented timing.
// -----------------------------------------------------------------------------
module tb_multiply_32_unit;

   localparam int N = 32;

   logic         clk;
   logic         reset;
   logic         enable;
   logic [N-1:0] multiplier;
   logic [N-1:0] multiplicand;
   logic         ready;
   logic [N-1:0] product_upper;
   logic [N-1:0] product_lower;
   logic         cout;

   int tests_run;
   int tests_failed;

   multiply_32_unit #(.N(N)) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .multiplier    (multiplier),
      .multiplicand  (multiplicand),
      .ready         (ready),
      .product_upper (product_upper),
      .product_lower (product_lower),
      .cout          (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [N-1:0] q, input logic [N-1:0] m);
      logic [63:0] wq;
      logic [63:0] wm;
      wq = {32'd0, q};
      wm = {32'd0, m};
      return wq * wm;
   endfunction

   // Waits (on falling edges) until ready rises; returns edges waited.
   task automatic wait_ready(output int cycles);
      cycles = 0;
      while (!ready && cycles < 100) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic check_result(input string tag, input logic [N-1:0] q, input logic [N-1:0] m);
      logic [63:0] exp;
      exp = ref_mul(q, m);
      check({tag, "_upper"}, 64'(product_upper), 64'(exp[63:32]));
      check({tag, "_lower"}, 64'(product_lower), 64'(exp[31:0]));
      check({tag, "_cout"}, 64'(cout), 64'd0);
      $display("[TB] mul %h x %h -> %h_%h (expect %h)", q, m, product_upper, product_lower, exp);
   endtask

   // One multiplication with a single start pulse. If poke_cycle > 0, a
   // spurious start with fresh operands is pulsed at that busy cycle.
   task automatic run_mul(input string tag, input logic [N-1:0] q, input logic [N-1:0] m,
                          input int poke_cycle);
      int cycles;
      @(negedge clk);
      multiplier   = q;
      multiplicand = m;
      enable       = 1'b1;
      @(negedge clk);
      enable       = 1'b0;
      multiplier   = $urandom;
      multiplicand = $urandom;
      check({tag, "_busy"}, 64'(ready), 64'd0);
      cycles = 0;
      while (!ready && cycles < 100) begin
         @(negedge clk);
         cycles++;
         enable = (cycles == poke_cycle);
         if (cycles == poke_cycle) begin
            multiplier   = $urandom;
            multiplicand = $urandom;
         end
      end
      enable = 1'b0;
      check({tag, "_latency"}, 64'(cycles), 64'(N));
      check_result(tag, q, m);
   endtask

   initial begin
      int          cycles;
      logic [N-1:0] rq;
      logic [N-1:0] rm;
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b0;
      enable       = 1'b0;
      multiplier   = '0;
      multiplicand = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ready", 64'(ready), 64'd1);
      check("rst_upper", 64'(product_upper), 64'd0);
      check("rst_lower", 64'(product_lower), 64'd0);
      check("rst_cout", 64'(cout), 64'd0);
      reset = 1'b1;

      // Directed cases
      run_mul("basic", 32'd2, 32'd2, 0);
      // Idle with enable low must hold the last product.
      repeat (3) @(negedge clk);
      check("hold_ready", 64'(ready), 64'd1);
      check_result("hold", 32'd2, 32'd2);
      run_mul("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_mul("carry_up", 32'h8000_0000, 32'd2, 0);
      run_mul("zero", 32'd0, 32'h1234_5678, 0);
      run_mul("busy_poke", 32'd3, 32'd5, 10);

      // Enable held high: result visible for exactly one ready cycle, then
      // the next operation starts with the operands present then.
      @(negedge clk);
      multiplier   = 32'd123457;
      multiplicand = 32'd98765;
      enable       = 1'b1;
      @(negedge clk);
      check("held_busy1", 64'(ready), 64'd0);
      wait_ready(cycles);
      check("held_latency1", 64'(cycles), 64'(N));
      check_result("held1", 32'd123457, 32'd98765);
      multiplier   = 32'hDEAD_BEEF;
      multiplicand = 32'h0BAD_F00D;
      @(negedge clk);
      check("held_restart", 64'(ready), 64'd0);
      wait_ready(cycles);
      enable = 1'b0;
      check("held_latency2", 64'(cycles), 64'(N));
      check_result("held2", 32'hDEAD_BEEF, 32'h0BAD_F00D);

      // Reset in the middle of an operation
      @(negedge clk);
      multiplier   = 32'hFFFF_FFFF;
      multiplicand = 32'hFFFF_FFFF;
      enable       = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      repeat (15) @(negedge clk);
      check("mid_busy", 64'(ready), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("mid_rst_ready", 64'(ready), 64'd1);
      check("mid_rst_upper", 64'(product_upper), 64'd0);
      check("mid_rst_lower", 64'(product_lower), 64'd0);
      check("mid_rst_cout", 64'(cout), 64'd0);
      run_mul("after_rst", 32'd7, 32'd6, 0);

      // Randomized operands, with occasional spurious enable pulses
      for (int i = 0; i < 24; i++) begin
         rq = $urandom;
         rm = $urandom;
         if (i % 6 == 1) rq = 32'hFFFF_FFFF;
         if (i % 6 == 2) rm = 32'h0000_0001;
         if (i % 6 == 3) rq = 32'(1) << $urandom_range(31, 0);
         run_mul("rand", rq, rm, (i % 3 == 0) ? int'($urandom_range(30, 1)) : 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
